param_sequence_generator: RTL

//   Parametrised successor of the fixed 4-phase fetch/decode/execute/increment sequencer.

---
 rtl/param_sequence_generator_pkg.sv | 8 +
 rtl/param_sequence_generator_counter.sv | 13 +
 rtl/param_sequence_generator.sv | 73 +++++++
 3 files changed

// File: rtl/param_sequence_generator_pkg.sv
// param_sequence_generator_pkg: shared step names and run/halt state encoding for the sequencer
package param_sequence_generator_pkg;
  localparam int unsigned STEP_FETCH     = 0;
  localparam int unsigned STEP_DECODE    = 1;
  localparam int unsigned STEP_EXECUTE   = 2;
  localparam int unsigned STEP_INCREMENT = 3;
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} seq_state_e;
endpackage

// File: rtl/param_sequence_generator_counter.sv
// sequence_cycle_counter: wrap-around completed-sequence counter with async clear and increment enable
module sequence_cycle_counter #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   enable,
  output logic [COUNT_WIDTH-1:0] count
);
  always_ff @(posedge clock or posedge clear)
    if (clear) count <= '0;
    else if (enable) count <= count + COUNT_WIDTH'(1);
endmodule

// File: rtl/param_sequence_generator.sv
// param_sequence_generator: one-hot timing-step sequencer with jump, early end, halt/resume and sequence count
module param_sequence_generator
  import param_sequence_generator_pkg::*;
#(
  parameter int STEP_COUNT  = 4,
  parameter int STEP_WIDTH  = 2,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   input_clear,
  input  logic                   input_clock_enable,
  input  logic                   input_restart,
  input  logic                   input_halt,
  input  logic                   input_resume,
  input  logic                   input_last,
  input  logic                   input_jump,
  input  logic [STEP_WIDTH-1:0]  input_jump_step,
  output logic [STEP_COUNT-1:0]  output_step,
  output logic [STEP_WIDTH-1:0]  output_step_index,
  output logic                   output_halted,
  output logic [COUNT_WIDTH-1:0] output_sequence_count
);
  if (STEP_COUNT < 2 || STEP_COUNT > 16 || STEP_WIDTH != $clog2(STEP_COUNT)) begin : g_bad_params
    $error("param_sequence_generator: STEP_COUNT must be 2..16 and STEP_WIDTH must be clog2(STEP_COUNT)");
  end
  localparam logic [STEP_WIDTH-1:0] FIRST = STEP_WIDTH'(STEP_FETCH);
  localparam logic [STEP_WIDTH-1:0] LAST  = STEP_WIDTH'(STEP_COUNT - 1);
  seq_state_e state, state_nx;
  logic [STEP_WIDTH-1:0] idx, idx_nx;
  logic is_final, jump_ok, count_inc;
  assign is_final = input_last || idx == LAST;
  assign jump_ok  = int'(input_jump_step) < STEP_COUNT;
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    count_inc = 1'b0;
    if (state == RUN) begin
      if (input_restart) idx_nx = FIRST;
      else if (input_halt) begin
        state_nx  = HALT;
        count_inc = is_final;
      end
      else if (input_jump) idx_nx = jump_ok ? input_jump_step : FIRST;
      else if (is_final) begin
        idx_nx    = FIRST;
        count_inc = 1'b1;
      end
      else idx_nx = idx + STEP_WIDTH'(1);
    end
    else if (input_restart || (input_resume && !input_halt)) begin
      state_nx = RUN;
      idx_nx   = FIRST;
    end
  end
  always_ff @(posedge clock or posedge input_clear)
    if (input_clear) begin
      state <= RUN;
      idx   <= FIRST;
    end
    else if (input_clock_enable) begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  sequence_cycle_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_count (
    .clock (clock),
    .clear (input_clear),
    .enable(input_clock_enable && count_inc),
    .count (output_sequence_count)
  );
  assign output_step       = state == HALT ? '0 : STEP_COUNT'(1) << idx;
  assign output_step_index = idx;
  assign output_halted     = state == HALT;
endmodule
